// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encoding and counter sizing for debounce_sync
package debounce_pkg;
   typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;
   function automatic int debounce_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction
endpackage

// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw input and conditioned outputs of debounce_sync
interface debounce_sync_if;
   logic din;
   logic level;
   logic rise;
   logic fall;
   logic busy;
   modport master (output din, input level, rise, fall, busy);
   modport slave (input din, output level, rise, fall, busy);
endinterface

// File: rtl/sync_chain.sv
// sync_chain: plain multi-flop synchroniser for one asynchronous bit
module sync_chain #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   // shift d through the chain with nothing between stages
   always_ff @(posedge clk or negedge reset)
      if (!reset) ff <= {STAGES{RESET_VAL}};
      else ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise and debounce one input into a clean level with edge strobes
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input logic            clk,
   input logic            reset,
   debounce_sync_if.slave bus
);
   localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic s, diff, done, level, level_n, rise, rise_n, fall, fall_n, busy;
   sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync (
      .clk(clk), .reset(reset), .d(bus.din), .q(s)
   );
   assign diff = s != level;
   assign done = diff && (state == CHECK ? cnt + 1'b1 == TERM : DEBOUNCE_CYCLES == 1);
   // leave CHECK on a flip or when s falls back into agreement
   always_comb state_n = (done || !diff) ? STABLE : CHECK;
   // run length of disagreement, flip value and strobes for this edge
   always_comb begin
      cnt_n   = (done || !diff) ? '0 : cnt + 1'b1;
      level_n = done ? s : level;
      rise_n  = done && s;
      fall_n  = done && !s;
   end
   // all observable state is registered
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= STABLE;
         cnt   <= '0;
         level <= RESET_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         level <= level_n;
         rise  <= rise_n;
         fall  <= fall_n;
         busy  <= state_n == CHECK;
      end
   assign bus.level = level;
   assign bus.rise  = rise;
   assign bus.fall  = fall;
   assign bus.busy  = busy;
endmodule
